// File: rtl/spi_mems_pkg.sv
// Shared types and constants for the MEMS SPI master.
// Mode-0 framing: SCLK idles low, data sampled on the rising edge.
package spi_mems_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_e;

  localparam int DATA_W_DEF = 16;
  localparam int NUM_CS_DEF = 4;
  localparam int CS_W_DEF   = 2;

  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;

endpackage

// File: rtl/spi_half_tick.sv
// Half-period timer: loads period-1 on restart and reloads itself,
// so tick fires on the last cycle of every period-long window.
module spi_half_tick (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        restart,
  input  logic [31:0] period,
  output logic        tick
);

  logic [31:0] cnt;

  assign tick = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= period - 32'd1;
    end else begin
      cnt <= cnt - 32'd1;
    end
  end

endmodule

// File: rtl/spi_master_mems.sv
// Single-frame full-duplex SPI mode-0 master for the MEMS sensors.
// Request is shadowed on acceptance; frame = SETUP, SHIFT, HOLD, GAP.
module spi_master_mems
  import spi_mems_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NUM_CS = NUM_CS_DEF,
  parameter int CS_W   = CS_W_DEF
) (
  input  logic              clk_150MHz_i,
  input  logic              reset,
  input  logic              enable,
  input  logic [31:0]       clk_div,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              addr_err,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);

  localparam int HW = $clog2(2 * DATA_W) + 1;
  localparam logic [HW-1:0] LAST = HW'(2 * DATA_W - 1);
  localparam logic [HW-1:0] LAST_FALL = HW'(2 * DATA_W - 2);

  state_e state, state_n;

  logic [31:0]       d_in, d_q;
  logic [HW-1:0]     hcnt;
  logic [DATA_W-1:0] tx_sr, rx_sr;
  logic [NUM_CS-1:0] cs_dec;
  logic addr_ok, tick, restart;
  logic accept, reject, rise, fall, shift_out;
  logic hold_done, gap_done;

  assign d_in    = (clk_div == '0) ? 32'd1 : clk_div;
  assign addr_ok = addr < 32'(NUM_CS);
  assign cs_dec  = ~(NUM_CS'(1) << addr[CS_W-1:0]);
  assign restart = (state == IDLE) || (state_n != state);

  spi_half_tick u_tick (
    .clk     (clk_150MHz_i),
    .rst_n   (reset),
    .restart (restart),
    .period  ((state == IDLE) ? d_in : d_q),
    .tick    (tick)
  );

  always_ff @(posedge clk_150MHz_i or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (enable && addr_ok) state_n = SETUP;
      SETUP: if (tick) state_n = SHIFT;
      SHIFT: if (tick && hcnt == LAST) state_n = HOLD;
      HOLD:  if (tick) state_n = GAP;
      GAP:   if (tick) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Even half-period ticks end a high phase, odd ones end a low phase;
  // the final tick only closes the last low phase.
  always_comb begin
    accept    = 1'b0;
    reject    = 1'b0;
    rise      = 1'b0;
    fall      = 1'b0;
    shift_out = 1'b0;
    hold_done = 1'b0;
    gap_done  = 1'b0;
    unique case (state)
      IDLE: begin
        accept = enable && addr_ok;
        reject = enable && !addr_ok;
      end
      SETUP: rise = tick;
      SHIFT: begin
        rise      = tick && hcnt[0] && (hcnt != LAST);
        fall      = tick && !hcnt[0];
        shift_out = tick && !hcnt[0] && (hcnt != LAST_FALL);
      end
      HOLD: hold_done = tick;
      GAP:  gap_done = tick;
      default: ;
    endcase
  end

  always_ff @(posedge clk_150MHz_i or negedge reset) begin
    if (!reset) begin
      busy     <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      addr_err <= 1'b0;
      sclk     <= CPOL;
      mosi     <= 1'b0;
      cs_n     <= '1;
      d_q      <= '0;
      hcnt     <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
    end else begin
      rx_valid <= hold_done;
      addr_err <= reject;
      if (accept) begin
        busy  <= 1'b1;
        d_q   <= d_in;
        hcnt  <= '0;
        tx_sr <= tx_data;
        mosi  <= tx_data[DATA_W-1];
        cs_n  <= cs_dec;
      end else begin
        if (gap_done) busy <= 1'b0;
        if (state == SHIFT && tick) hcnt <= hcnt + 1'b1;
        if (shift_out) begin
          tx_sr <= tx_sr << 1;
          mosi  <= tx_sr[DATA_W-2];
        end
        if (hold_done) begin
          rx_data <= rx_sr;
          cs_n    <= '1;
          mosi    <= 1'b0;
        end
      end
      if (rise) begin
        sclk  <= ~CPOL;
        rx_sr <= {rx_sr[DATA_W-2:0], miso};
      end else if (fall) begin
        sclk <= CPOL;
      end
    end
  end

endmodule

// File: doc/spi_master_mems.md
Name: spi_master_mems

Overview:
- Downstream stage of the SPI command controller; consumes its `clk_div`, `addr`, `tx_data` and `enable`, and returns `busy`.
- Runs one full-duplex SPI mode-0 frame of DATA_W bits, MSB first, to the MEMS device selected by `addr`.
- Returns the received word with a one-cycle valid strobe.
- All logic runs in the 150 MHz system domain; SCLK is a registered, divided output.

Parameters:
- DATA_W, 16, frame length in bits (range 2..32).
- NUM_CS, 4, number of chip-select lines.
- CS_W, 2, index width; must equal clog2(NUM_CS).

Ports:
- clk_150MHz_i  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- enable  in  1  start request; sampled only in IDLE.
- clk_div  in  32  SCLK half-period in system cycles; 0 is treated as 1.
- addr  in  32  chip-select index.
- tx_data  in  DATA_W  word to transmit.
- busy  out  1  high while a frame is in progress.
- rx_data  out  DATA_W  last received word.
- rx_valid  out  1  one-cycle strobe; rx_data is new.
- addr_err  out  1  one-cycle strobe; request rejected because addr >= NUM_CS.
- sclk  out  1  SPI clock, idle low.
- mosi  out  1  serial data out.
- miso  in  1  serial data in.
- cs_n  out  NUM_CS  active-low chip selects, one-hot-low when active.

Behaviour:
- Reset values (asserted asynchronously): busy=0, rx_valid=0, addr_err=0, rx_data=0, sclk=0, mosi=0, cs_n=all 1s, state=IDLE, all counters=0.
- State encoding: IDLE, SETUP, SHIFT, HOLD, GAP. A half-period tick fires every D cycles, where D = max(clk_div,1). The tick counter restarts on each state entry.
- IDLE, enable=1, addr<NUM_CS:
  - On this edge: latch D, addr[CS_W-1:0] and tx_data into shadow registers.
  - Drive cs_n[idx]=0 and mosi=tx_data[DATA_W-1].
  - Set busy=1 (visible the next cycle) and enter SETUP.
- IDLE, enable=1, addr>=NUM_CS:
  - Pulse addr_err for 1 cycle.
  - Busy stays 0, no CS asserted, remain in IDLE.
- SETUP: lasts D cycles (CS-to-first-edge setup time), then go to SHIFT with sclk rising.
- SHIFT: 2*DATA_W half-periods.
  - Rising sclk: sample miso into the shift register LSB on the same system edge that sets sclk=1.
  - Falling sclk: shift out the next bit on mosi.
  - After the final falling edge (sclk=0), go to HOLD.
  - mosi holds the last bit through HOLD.
- HOLD: lasts D cycles.
  - On exit: rx_data is loaded with the shift register, rx_valid pulses 1 cycle, cs_n returns to all 1s, mosi=0.
  - Then enter GAP.
- GAP: lasts D cycles of minimum CS-high time. On exit: busy=0, enter IDLE.
- Timing:
  - busy is high for exactly (2*DATA_W+3)*D cycles per frame.
  - rx_valid fires exactly once per accepted frame, D cycles before busy falls.
- enable is ignored while busy=1.
- Input changes mid-frame have no effect; shadow registers are used.
- An enable held high or re-asserted in the first IDLE cycle after busy falls starts a new frame back-to-back. This is compatible with the controller toggling enable every cycle while !busy.
- Reset asserted mid-frame:
  - Immediate abort: cs_n all 1s, sclk=0, mosi=0, busy=0.
  - No rx_valid; rx_data is cleared to 0.
- D is 32-bit. The counter compares against D-1 with no overflow path.
- The tick counter is 32 bits wide.

Decomposition:
- Package spi_mems_pkg holds:
  - The state enum (IDLE, SETUP, SHIFT, HOLD, GAP).
  - The default-width localparams and the SPI mode-0 constants CPOL=0 and CPHA=0.
- Sub-module spi_half_tick: loadable down-counter with a restart input; emits a tick every D cycles.
- The FSM, shift registers and CS decode stay in the top module.

Test Plan:
- Frame content and timing:
  - Stimulus: reset released, clk_div=1, addr=0, tx_data=16'hF500, miso looped to mosi.
  - Required: cs_n=4'b1110, 16 sclk pulses, 75 MHz, MOSI bits 1111010100000000.
  - Required: rx_valid with rx_data=16'hF500; busy high exactly 35 cycles.
- Divider and chip select:
  - Stimulus: clk_div=4, addr=3, tx_data=16'hA5C3, miso tied 1.
  - Required: sclk half-period 4 cycles, cs_n=4'b0111, busy high 140 cycles, rx_data=16'hFFFF.
- Divide-by-zero:
  - Stimulus: clk_div=0.
  - Required: identical waveform to clk_div=1.
- Address error:
  - Stimulus: addr=5 with enable pulsed.
  - Required: addr_err high 1 cycle, busy stays 0, cs_n stays 4'b1111, sclk stays 0.
- Back-to-back frames:
  - Stimulus: enable toggled every !busy cycle (controller behaviour); tx_data changed to 16'h1234 mid-frame.
  - Required: first frame still sends 16'hF500, second sends 16'h1234.
  - Required: GAP of at least D cycles with cs_n high between frames; exactly one rx_valid per frame.
- Reset mid-frame:
  - Stimulus: reset driven low during bit 7 of SHIFT.
  - Required: outputs reach reset values without waiting for a clock edge, no rx_valid.
  - Required: after reset release, the next enable gives a clean frame.
